// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb -- general-purpose register file with an issue scoreboard.
//
// Holds NREGS registers of XLEN bits (register 0 hardwired to zero) and one
// pending bit per register. The pending bit is set when an instruction that
// writes the register issues, and cleared when its write-back arrives, so that
// issue logic can stall on operands that are still in flight.
//
// Parameters
//   XLEN   : register width in bits
//   NREGS  : register count (power of two, >= 2); AW = log2(NREGS)
//   NRD    : number of independent combinational read ports (1..4)
//   BYPASS : 1 forwards a same-cycle write-back to the read ports
//
// Ports
//   clk      : clock, all state updates on the rising edge
//   rst_n    : asynchronous active-low reset, clears registers and scoreboard
//   we/wa/wd : write-back enable, address, data
//   ra       : NRD packed read addresses, port i at [i*AW +: AW]
//   rd       : NRD packed read data, port i at [i*XLEN +: XLEN]
//   rbusy    : per-port "operand still pending" flag
//   iss_v    : issue strobe, marks iss_a as pending
//   iss_a    : destination register of the issuing instruction
//   busy_vec : registered pending bit of every register (bit 0 always 0)
// -----------------------------------------------------------------------------
module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [AW-1:0]        wa,
  input  logic [XLEN-1:0]      wd,
  input  logic [NRD*AW-1:0]    ra,
  output logic [NRD*XLEN-1:0]  rd,
  output logic [NRD-1:0]       rbusy,
  input  logic                 iss_v,
  input  logic [AW-1:0]        iss_a,
  output logic [NREGS-1:0]     busy_vec
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] pend_q;
  logic [NREGS-1:0] pend_d;

  logic wr_en;
  logic iss_en;

  // Register 0 never accepts a write or an issue.
  assign wr_en  = we    && (wa    != '0);
  assign iss_en = iss_v && (iss_a != '0);

  // Next-state for the data array and the scoreboard.
  // NOTE: every combinational output starts from a full default (hold the
  // current state) before the conditional updates, so no latch can be inferred.
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    if (wr_en) begin
      regs_d[wa] = wd;
      pend_d[wa] = 1'b0;
    end
    // Issue is applied after write-back so a same-register collision
    // leaves the bit set: the newer instruction still owes a result.
    if (iss_en) begin
      pend_d[iss_a] = 1'b1;
    end
    regs_d[0] = '0;
    pend_d[0] = 1'b0;
  end

  // NOTE: the data array is reset along with the scoreboard because reads must
  // return 0 immediately on reset; sequential state uses non-blocking
  // assignments only, so every flop samples the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  // Read ports. Forwarding is additionally gated by rst_n: while reset is held
  // the write-back port is ignored, so nothing may leak through the bypass.
  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0] addr;
    logic          fwd;

    assign addr = ra[g*AW +: AW];
    assign fwd  = (BYPASS != 0) && rst_n && wr_en && (wa == addr);

    assign rd[g*XLEN +: XLEN] = fwd ? wd : regs_q[addr];
    // A write-back arriving this cycle satisfies the operand, so it is not busy.
    assign rbusy[g] = pend_q[addr] & ~fwd;
  end

  assign busy_vec = pend_q;

endmodule

// File: tb/tb_regfile_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_sb -- directed self-checking bench for regfile_sb.
//
// Two instances share clk and rst_n:
//   u_dut_a : default parameters (XLEN 32, NREGS 32, NRD 2, BYPASS 1)
//   u_dut_b : XLEN 32, NREGS 16, NRD 4, BYPASS 0
// Inputs change 2 time units after a rising edge; outputs are sampled 1 unit
// later, well clear of either clock edge.
// -----------------------------------------------------------------------------
module tb_regfile_sb;

  logic clk;
  logic rst_n;

  // Instance A signals
  logic        we_a;
  logic [4:0]  wa_a;
  logic [31:0] wd_a;
  logic [9:0]  ra_a;
  logic [63:0] rd_a;
  logic [1:0]  rbusy_a;
  logic        iss_v_a;
  logic [4:0]  iss_a_a;
  logic [31:0] busy_a;

  // Instance B signals
  logic         we_b;
  logic [3:0]   wa_b;
  logic [31:0]  wd_b;
  logic [15:0]  ra_b;
  logic [127:0] rd_b;
  logic [3:0]   rbusy_b;
  logic         iss_v_b;
  logic [3:0]   iss_a_b;
  logic [15:0]  busy_b;

  int checks;
  int errors;

  regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1)) u_dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we_a),
    .wa       (wa_a),
    .wd       (wd_a),
    .ra       (ra_a),
    .rd       (rd_a),
    .rbusy    (rbusy_a),
    .iss_v    (iss_v_a),
    .iss_a    (iss_a_a),
    .busy_vec (busy_a)
  );

  regfile_sb #(.XLEN(32), .NREGS(16), .NRD(4), .BYPASS(0)) u_dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we_b),
    .wa       (wa_b),
    .wd       (wd_b),
    .ra       (ra_b),
    .rd       (rd_b),
    .rbusy    (rbusy_b),
    .iss_v    (iss_v_b),
    .iss_a    (iss_a_b),
    .busy_vec (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    we_a    = 1'b0; wa_a = '0; wd_a = '0; ra_a = '0; iss_v_a = 1'b0; iss_a_a = '0;
    we_b    = 1'b0; wa_b = '0; wd_b = '0; ra_b = '0; iss_v_b = 1'b0; iss_a_b = '0;

    // ---------------- reset state ----------------
    #1;
    check("rst_rd_a",    rd_a,    '0);
    check("rst_rbusy_a", rbusy_a, '0);
    check("rst_busy_a",  busy_a,  '0);
    check("rst_rd_b",    rd_b,    '0);
    check("rst_busy_b",  busy_b,  '0);
    tick();
    rst_n = 1'b1;
    tick();

    // ---------------- write then read with forwarding ----------------
    we_a = 1'b1; wa_a = 5'd5; wd_a = 32'hDEADBEEF; ra_a = {5'd0, 5'd5};
    #1;
    check("bypass_rd0",   rd_a, {32'h0, 32'hDEADBEEF});
    tick();
    we_a = 1'b0;
    #1;
    check("stored_rd0",   rd_a, {32'h0, 32'hDEADBEEF});

    // ---------------- x0 protection ----------------
    we_a = 1'b1; wa_a = 5'd0; wd_a = 32'hFFFFFFFF;
    iss_v_a = 1'b1; iss_a_a = 5'd0; ra_a = {5'd0, 5'd0};
    #1;
    check("x0_rd_same_cycle", rd_a,    64'h0);
    check("x0_rbusy",         rbusy_a, 2'b00);
    tick();
    we_a = 1'b0; iss_v_a = 1'b0;
    #1;
    check("x0_rd_after",   rd_a,   64'h0);
    check("x0_busy_vec",   busy_a, 32'h0);

    // ---------------- scoreboard lifecycle on reg 7 ----------------
    iss_v_a = 1'b1; iss_a_a = 5'd7;
    tick();
    iss_v_a = 1'b0; ra_a = {5'd7, 5'd7};
    #1;
    check("sb_busy_vec_set", busy_a,  32'h0000_0080);
    check("sb_rbusy_set",    rbusy_a, 2'b11);
    we_a = 1'b1; wa_a = 5'd7; wd_a = 32'h0000_0077;
    #1;
    check("sb_rbusy_fwd",    rbusy_a, 2'b00);
    check("sb_rd_fwd",       rd_a,    {32'h77, 32'h77});
    check("sb_busy_vec_reg", busy_a,  32'h0000_0080);
    tick();
    we_a = 1'b0;
    #1;
    check("sb_busy_vec_clr", busy_a,  32'h0);
    check("sb_rd_stored",    rd_a,    {32'h77, 32'h77});

    // ---------------- same-edge collision on reg 9 ----------------
    iss_v_a = 1'b1; iss_a_a = 5'd9;
    tick();
    we_a = 1'b1; wa_a = 5'd9; wd_a = 32'h0000_0099;
    ra_a = {5'd9, 5'd5};
    #1;
    check("coll_rbusy_fwd", rbusy_a, 2'b00);
    tick();
    we_a = 1'b0; iss_v_a = 1'b0;
    #1;
    check("coll_busy_vec",  busy_a, 32'h0000_0200);
    check("coll_rd",        rd_a,   {32'h99, 32'hDEADBEEF});
    check("coll_rbusy",     rbusy_a, 2'b10);

    // ---------------- issue and write-back to different registers ----------------
    iss_v_a = 1'b1; iss_a_a = 5'd3;
    we_a = 1'b1; wa_a = 5'd9; wd_a = 32'h0000_00AA;
    tick();
    // Write-back to a register that is not pending.
    iss_v_a = 1'b0;
    we_a = 1'b1; wa_a = 5'd4; wd_a = 32'h0000_0444;
    tick();
    we_a = 1'b0; ra_a = {5'd4, 5'd9};
    #1;
    check("diff_busy_vec",  busy_a, 32'h0000_0008);
    check("diff_rd",        rd_a,   {32'h444, 32'hAA});

    // ---------------- fill, mark pending, then async reset ----------------
    for (int i = 1; i < 32; i++) begin
      we_a = 1'b1; wa_a = i[4:0]; wd_a = 32'(i);
      tick();
    end
    we_a = 1'b0;
    iss_v_a = 1'b1; iss_a_a = 5'd2;  tick();
    iss_a_a = 5'd11; tick();
    iss_a_a = 5'd30; tick();
    iss_v_a = 1'b0;
    ra_a = {5'd17, 5'd31};
    #1;
    check("fill_rd",       rd_a,   {32'd17, 32'd31});
    check("fill_busy_vec", busy_a, 32'h4000_0804);
    // Mid-cycle reset with a write-back and issue presented: both must be ignored.
    #1;
    we_a = 1'b1; wa_a = 5'd31; wd_a = 32'h1234_5678;
    iss_v_a = 1'b1; iss_a_a = 5'd12;
    rst_n = 1'b0;
    #1;
    check("arst_rd",       rd_a,    64'h0);
    check("arst_busy_vec", busy_a,  32'h0);
    check("arst_rbusy",    rbusy_a, 2'b00);
    tick();
    #1;
    check("arst_hold_rd",   rd_a,   64'h0);
    check("arst_hold_busy", busy_a, 32'h0);

    // ---------------- reset release: first sampling edge updates state ----------------
    iss_v_a = 1'b0;
    we_a = 1'b1; wa_a = 5'd6; wd_a = 32'h0000_0066; ra_a = {5'd31, 5'd6};
    #1;
    rst_n = 1'b1;
    tick();
    we_a = 1'b0;
    #1;
    check("release_rd", rd_a, {32'h0, 32'h66});

    // ---------------- instance B: NRD=4, NREGS=16, BYPASS=0 ----------------
    we_b = 1'b1; wa_b = 4'd1;  wd_b = 32'h11; tick();
    wa_b = 4'd2;  wd_b = 32'h22; tick();
    wa_b = 4'd3;  wd_b = 32'h33; tick();
    wa_b = 4'd15; wd_b = 32'hFF; tick();
    we_b = 1'b0;
    ra_b = {4'd15, 4'd3, 4'd2, 4'd1};
    #1;
    check("b_par_read", rd_b, {32'hFF, 32'h33, 32'h22, 32'h11});
    we_b = 1'b1; wa_b = 4'd2; wd_b = 32'hABCD;
    ra_b = {4{4'd2}};
    #1;
    check("b_no_bypass", rd_b, {4{32'h22}});
    tick();
    we_b = 1'b0;
    #1;
    check("b_after_edge", rd_b, {4{32'hABCD}});

    iss_v_b = 1'b1; iss_a_b = 4'd5;
    tick();
    iss_v_b = 1'b0; ra_b = {4{4'd5}};
    #1;
    check("b_busy_vec", busy_b,  16'h0020);
    check("b_rbusy",    rbusy_b, 4'hF);
    we_b = 1'b1; wa_b = 4'd5; wd_b = 32'h55;
    #1;
    check("b_rbusy_nofwd", rbusy_b, 4'hF);
    check("b_rd_nofwd",    rd_b,    128'h0);
    tick();
    we_b = 1'b0;
    #1;
    check("b_rbusy_clr", rbusy_b, 4'h0);
    check("b_rd_wb",     rd_b,    {4{32'h55}});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
- REQ-001: Parameter XLEN, default 32, data width of every register in bits.
- REQ-002: Parameter NREGS, default 32, register count, power of two, at least 2; AW = log2(NREGS) is the address width.
- REQ-003: Parameter NRD, default 2, number of independent read ports, 1 to 4.
- REQ-004: Parameter BYPASS, default 1; 1 forwards the same-cycle write to reads, 0 returns the stored value.
- REQ-005: clk, input, 1, single clock; all state updates on its rising edge.
- REQ-006: rst_n, input, 1, reset, asynchronous and active-low.
- REQ-007: we, input, 1, write-back enable.
- REQ-008: wa, input, AW, write-back address.
- REQ-009: wd, input, XLEN, write-back data.
- REQ-010: ra, input, NRD*AW, read addresses; port i occupies bits [i*AW +: AW].
- REQ-011: rd, output, NRD*XLEN, read data; port i occupies bits [i*XLEN +: XLEN].
- REQ-012: rbusy, output, NRD, bit i set means ra port i names a register with a write-back still pending.
- REQ-013: iss_v, input, 1, issue strobe; marks register iss_a as pending.
- REQ-014: iss_a, input, AW, destination register of the issuing instruction.
- REQ-015: busy_vec, output, NREGS, current pending bit of every register; bit 0 is always 0.

Function
- REQ-016: Register 0 is hardwired to zero: a write to it is discarded, it reads 0, and it is never marked pending.
- REQ-017: When we=1 and wa!=0, the register file stores wd into register wa on the rising clock edge.
- REQ-018: Read ports are combinational and mutually independent; any number of them may name the same register.
- REQ-019: BYPASS=1: if we=1 and wa==ra[i]!=0, rd[i] shows wd in the same cycle (zero-latency forwarding); otherwise rd[i] shows the stored value.
- REQ-020: BYPASS=0: rd[i] shows the stored value, and a write becomes visible in the cycle after its edge.
- REQ-021: Scoreboard: per register, one pending bit, reset to 0.
- REQ-022: A rising edge with iss_v=1 and iss_a!=0 sets pending[iss_a].
- REQ-023: A rising edge with we=1 and wa!=0 clears pending[wa].
- REQ-024: Issue and write-back to the same register on the same edge leave the bit set (the issue wins).
- REQ-025: Issue and write-back to different registers on the same edge both take effect.
- REQ-026: A write-back to a register that is not pending is legal; it updates the data and leaves the bit 0.
- REQ-027: rbusy[i] = pending[ra[i]] AND NOT (BYPASS=1 AND we=1 AND wa==ra[i]); a forwarded write-back is treated as not busy.
- REQ-028: busy_vec reflects registered state only; no bypass term applies to it.
- REQ-029: Multi-bit outputs have no X or undefined bits after reset, for every parameter set.

Reset
- REQ-030: rst_n=0 asynchronously clears every register to 0 and every pending bit to 0.
- REQ-031: Outputs follow reset without waiting for a clock edge: rd=0, rbusy=0, busy_vec=0.
- REQ-032: While rst_n=0, we and iss_v are ignored.
- REQ-033: Release of rst_n is synchronous to clk: the first edge at which state can change is the first rising edge that samples rst_n=1.
- REQ-034: Reset asserted mid-operation discards pending writes and the scoreboard with no partial update.

Verification
- REQ-035: Write then read, BYPASS=1: we=1, wa=5, wd=0xDEADBEEF, ra0=5 in the same cycle -> rd0=0xDEADBEEF before the edge; after the edge with we=0 -> rd0=0xDEADBEEF.
- REQ-036: x0 protection: we=1, wa=0, wd=0xFFFFFFFF; iss_v=1, iss_a=0 -> rd for ra=0 stays 0 and busy_vec[0]=0.
- REQ-037: Scoreboard lifecycle: issue reg 7 -> busy_vec[7]=1 and rbusy0=1 with ra0=7; write-back reg 7 with BYPASS=1 -> rbusy0=0 in that cycle, busy_vec[7]=0 after the edge.
- REQ-038: Same-edge collision: iss_a=9 and wa=9 on one edge with reg 9 pending -> busy_vec[9]=1 afterwards and reg 9 holds wd.
- REQ-039: Async reset: fill regs 1..31 with index values and mark 3 regs pending, then assert rst_n=0 between edges -> all rd=0 and busy_vec=0 immediately, without a clock edge.
- REQ-040: Parameter sweep: NRD=4, NREGS=16, BYPASS=0 -> all four ports read in parallel correctly, and a written value appears one cycle after its edge.
